dcache_wb_buffer: RTL and testbench

Write-back buffer directly downstream of the dcache data array. It captures dirty victim blocks evicted by the cache, queues them in FIFO order and drains them to mem.v as BUS_STORE requests whenever the memory arbiter grants the bus. Miss lookups are forwarded from the buffer so a load never reads stale memory while its block is still pending write-back.

---
 rtl/dcache_wb_buffer.sv | 123 ++++++++++++
 tb/tb_dcache_wb_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache and memory: queues dirty victims in FIFO
// order, coalesces repeat victims, drains them as BUS_STORE and forwards pending data to misses.
module dcache_wb_buffer #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 64,
    parameter int BLK_W    = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      evict_valid,
    input  logic [ADDR_W-1:0]         evict_addr,
    input  logic [BLK_W-1:0]          evict_data,
    output logic                      evict_ready,
    input  logic [ADDR_W-1:0]         lookup_addr,
    output logic                      lookup_hit,
    output logic [BLK_W-1:0]          lookup_data,
    input  logic                      mem_grant,
    input  logic [3:0]                mem2wb_response,
    output logic [1:0]                wb2mem_command,
    output logic [ADDR_W-1:0]         wb2mem_addr,
    output logic [BLK_W-1:0]          wb2mem_data,
    output logic [$clog2(WB_DEPTH):0] wb_count,
    output logic                      wb_empty
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - 3;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [WB_DEPTH-1:0] valid;
    logic [TAG_W-1:0]    tags     [WB_DEPTH];
    logic [BLK_W-1:0]    data_mem [WB_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;

    logic [TAG_W-1:0] evict_tag;
    logic [TAG_W-1:0] lookup_tag;
    logic             issue;
    logic             dequeue;
    logic             accept;
    logic             allocate;
    logic             evict_hit;
    logic [PTR_W-1:0] evict_idx;
    logic             lookup_found;
    logic [PTR_W-1:0] lookup_idx;
    logic             unused_low_bits;

    assign evict_tag       = evict_addr[ADDR_W-1:3];
    assign lookup_tag      = lookup_addr[ADDR_W-1:3];
    assign unused_low_bits = ^{evict_addr[2:0], lookup_addr[2:0]};

    assign evict_ready = (count < CNT_W'(WB_DEPTH));
    assign issue       = (count != '0) && mem_grant;
    assign dequeue     = issue && (mem2wb_response != 4'd0);
    assign accept      = evict_valid && evict_ready;
    assign allocate    = accept && !evict_hit;

    // A duplicate block can only exist as head plus one younger copy, so any
    // non-head match takes precedence over the head.
    always_comb begin
        evict_hit    = 1'b0;
        evict_idx    = '0;
        lookup_found = 1'b0;
        lookup_idx   = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (valid[i] && tags[i] == evict_tag
                && !(dequeue && PTR_W'(i) == head)
                && (!evict_hit || PTR_W'(i) != head)) begin
                evict_hit = 1'b1;
                evict_idx = PTR_W'(i);
            end
            if (valid[i] && tags[i] == lookup_tag
                && (!lookup_found || PTR_W'(i) != head)) begin
                lookup_found = 1'b1;
                lookup_idx   = PTR_W'(i);
            end
        end
    end

    assign lookup_hit  = lookup_found;
    assign lookup_data = lookup_found ? data_mem[lookup_idx] : '0;

    assign wb2mem_command = issue ? BUS_STORE : BUS_NONE;
    assign wb2mem_addr    = issue ? {tags[head], 3'b000} : '0;
    assign wb2mem_data    = issue ? data_mem[head] : '0;

    assign wb_count = count;
    assign wb_empty = (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (allocate) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (dequeue) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CNT_W'(allocate) - CNT_W'(dequeue);
        end
    end

    // Payload storage carries no reset; validity alone decides what is live.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (accept && evict_hit) begin
                data_mem[evict_idx] <= evict_data;
            end
            if (allocate) begin
                tags[tail]     <= evict_tag;
                data_mem[tail] <= evict_data;
            end
        end
    end
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_dcache_wb_buffer;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        evict_valid;
    logic [63:0] evict_addr;
    logic [63:0] evict_data;
    logic        evict_ready;
    logic [63:0] lookup_addr;
    logic        lookup_hit;
    logic [63:0] lookup_data;
    logic        mem_grant;
    logic [3:0]  mem2wb_response;
    logic [1:0]  wb2mem_command;
    logic [63:0] wb2mem_addr;
    logic [63:0] wb2mem_data;
    logic [2:0]  wb_count;
    logic        wb_empty;

    int assertions = 0;
    int failures   = 0;

    logic [63:0] m_addr[$];
    logic [63:0] m_data[$];

    dcache_wb_buffer #(.WB_DEPTH(DEPTH), .ADDR_W(64), .BLK_W(64)) dut (
        .clock(clock),
        .reset(reset),
        .evict_valid(evict_valid),
        .evict_addr(evict_addr),
        .evict_data(evict_data),
        .evict_ready(evict_ready),
        .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit),
        .lookup_data(lookup_data),
        .mem_grant(mem_grant),
        .mem2wb_response(mem2wb_response),
        .wb2mem_command(wb2mem_command),
        .wb2mem_addr(wb2mem_addr),
        .wb2mem_data(wb2mem_data),
        .wb_count(wb_count),
        .wb_empty(wb_empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Youngest queued copy of a block; optionally ignore the head slot.
    function automatic int youngestMatch(input logic [63:0] a, input bit skip_head);
        for (int i = m_addr.size() - 1; i >= 0; i--) begin
            if (m_addr[i][63:3] == a[63:3] && !(skip_head && i == 0)) return i;
        end
        return -1;
    endfunction

    task automatic checkAgainstModel();
        bit issue;
        int idx;
        issue = (m_addr.size() > 0) && mem_grant;
        idx   = youngestMatch(lookup_addr, 1'b0);
        checkOutput("evict_ready", evict_ready, m_addr.size() < DEPTH);
        checkOutput("wb_count", wb_count, m_addr.size());
        checkOutput("wb_empty", wb_empty, m_addr.size() == 0);
        checkOutput("wb2mem_command", wb2mem_command, issue ? 2 : 0);
        checkOutput("wb2mem_addr", wb2mem_addr, issue ? m_addr[0] : 64'd0);
        checkOutput("wb2mem_data", wb2mem_data, issue ? m_data[0] : 64'd0);
        checkOutput("lookup_hit", lookup_hit, idx >= 0);
        checkOutput("lookup_data", lookup_data, (idx >= 0) ? m_data[idx] : 64'd0);
    endtask

    task automatic modelStep();
        bit ready;
        bit deq;
        int idx;
        if (reset) begin
            m_addr.delete();
            m_data.delete();
        end else begin
            ready = m_addr.size() < DEPTH;
            deq   = (m_addr.size() > 0) && mem_grant && (mem2wb_response != 0);
            if (evict_valid && ready) begin
                idx = youngestMatch(evict_addr, deq);
                if (idx >= 0) begin
                    m_data[idx] = evict_data;
                end else begin
                    m_addr.push_back({evict_addr[63:3], 3'b000});
                    m_data.push_back(evict_data);
                end
            end
            if (deq) begin
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
            end
        end
    endtask

    // Drive one cycle's inputs and compare outputs at mid-cycle.
    task automatic applyStimulus(input logic ev, input logic [63:0] ea, input logic [63:0] ed,
                                 input logic [63:0] la, input logic gr, input logic [3:0] resp,
                                 input logic rst);
        evict_valid     = ev;
        evict_addr      = ea;
        evict_data      = ed;
        lookup_addr     = la;
        mem_grant       = gr;
        mem2wb_response = resp;
        reset           = rst;
        #4;
        checkAgainstModel();
    endtask

    task automatic clockEdge();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic cycle(input logic ev, input logic [63:0] ea, input logic [63:0] ed,
                         input logic [63:0] la, input logic gr, input logic [3:0] resp);
        applyStimulus(ev, ea, ed, la, gr, resp, 1'b0);
        clockEdge();
    endtask

    initial begin
        logic [63:0] drain_order[4];
        $display("[TB] starting dcache_wb_buffer test");
        evict_valid = 0; evict_addr = 0; evict_data = 0; lookup_addr = 0;
        mem_grant = 0; mem2wb_response = 0; reset = 1;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        applyStimulus(0, 0, 0, 64'h100, 0, 0, 0);
        checkOutput("rst_ready", evict_ready, 1);
        checkOutput("rst_empty", wb_empty, 1);
        checkOutput("rst_count", wb_count, 0);
        checkOutput("rst_cmd", wb2mem_command, 0);
        clockEdge();

        // Single victim, visible to lookup by its block address
        cycle(1, 64'h100, 64'hAAAA, 0, 0, 0);
        applyStimulus(0, 0, 0, 64'h104, 0, 0, 0);
        checkOutput("t1_count", wb_count, 1);
        checkOutput("t1_cmd", wb2mem_command, 0);
        checkOutput("t1_hit", lookup_hit, 1);
        checkOutput("t1_data", lookup_data, 64'hAAAA);
        clockEdge();

        // Rejected stores are retried until accepted
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, (i == 2) ? 4'd3 : 4'd0, 0);
            checkOutput("t2_cmd", wb2mem_command, 2);
            checkOutput("t2_addr", wb2mem_addr, 64'h100);
            checkOutput("t2_data", wb2mem_data, 64'hAAAA);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_count_after", wb_count, 0);
        checkOutput("t2_cmd_after", wb2mem_command, 0);
        clockEdge();

        // Coalescing keeps original order with newest data
        cycle(1, 64'h100, 64'h1111, 0, 0, 0);
        cycle(1, 64'h200, 64'h2222, 0, 0, 0);
        cycle(1, 64'h100, 64'h3333, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t3_count", wb_count, 2);
        checkOutput("t3_addr0", wb2mem_addr, 64'h100);
        checkOutput("t3_data0", wb2mem_data, 64'h3333);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t3_addr1", wb2mem_addr, 64'h200);
        checkOutput("t3_data1", wb2mem_data, 64'h2222);
        clockEdge();

        // Full buffer rejects, then accepts after one dequeue
        for (int i = 0; i < 4; i++) cycle(1, 64'(i * 8), 64'(32'hD000 + i), 0, 0, 0);
        applyStimulus(1, 64'h020, 64'hEEEE, 0, 0, 0, 0);
        checkOutput("t4_full_ready", evict_ready, 0);
        clockEdge();
        applyStimulus(1, 64'h020, 64'hEEEE, 0, 1, 1, 0);
        checkOutput("t4_count_full", wb_count, 4);
        clockEdge();
        applyStimulus(1, 64'h020, 64'hEEEE, 0, 0, 0, 0);
        checkOutput("t4_ready_after", evict_ready, 1);
        clockEdge();
        drain_order = '{64'h008, 64'h010, 64'h018, 64'h020};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 0);
            checkOutput("t4_drain_addr", wb2mem_addr, drain_order[i]);
            clockEdge();
        end

        // Head exception: victim of the dequeuing head allocates a new entry
        cycle(1, 64'h100, 64'hAAAA, 0, 0, 0);
        applyStimulus(1, 64'h100, 64'hBBBB, 0, 1, 2, 0);
        checkOutput("t5_store_data", wb2mem_data, 64'hAAAA);
        clockEdge();
        applyStimulus(0, 0, 0, 64'h100, 0, 0, 0);
        checkOutput("t5_count", wb_count, 1);
        checkOutput("t5_lookup", lookup_data, 64'hBBBB);
        clockEdge();
        cycle(0, 0, 0, 0, 1, 1);

        // Reset during a granted store drops everything
        cycle(1, 64'h300, 64'h3000, 0, 0, 0);
        cycle(1, 64'h308, 64'h3008, 0, 0, 0);
        cycle(1, 64'h310, 64'h3010, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        clockEdge();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 64'(64'h300 + i * 8), 1, 1, 0);
            checkOutput("t6_count", wb_count, 0);
            checkOutput("t6_empty", wb_empty, 1);
            checkOutput("t6_cmd", wb2mem_command, 0);
            checkOutput("t6_hit", lookup_hit, 0);
            clockEdge();
        end

        // Randomized traffic over a small block pool to exercise coalescing
        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(0, 9) < 6,
                          64'(($urandom_range(0, 5) * 8 + 64'h400) | $urandom_range(0, 7)),
                          {$urandom(), $urandom()},
                          64'(($urandom_range(0, 6) * 8 + 64'h400) | $urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 3)),
                          $urandom_range(0, 63) == 0);
            clockEdge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
